uart_receiver_param: RTL and testbench

Parametrised serial receiver: the next generation of the team's UART_receiver. It adds a configurable frame format (data width, runtime parity mode, one or two stop bits), a derived baud table, false-start rejection and break detection. It sits between the RxD pad and the host register interface, one instance per serial channel. It presents each received word with a one-cycle valid strobe and held error flags.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/baud_controller.sv | 52 +++++
 rtl/uart_receiver_param.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_receiver_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, parity codes and baud table for uart_receiver_param
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  function automatic int baud_rate(input logic [2:0] code);
    case (code)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded divisor for a 16x oversample tick.
  function automatic int baud_divisor(input int clk_freq, input int baud);
    return (clk_freq + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/baud_controller.sv
// rtl/baud_controller.sv - 16x oversample tick generator, restarts on any baud_select change
module baud_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_tick
);

  localparam int CW = $clog2(baud_divisor(CLK_FREQ, baud_rate(3'd0)) + 1);

  typedef logic [7:0][CW-1:0] div_table_t;

  function automatic div_table_t build_table();
    div_table_t t;
    for (int i = 0; i < 8; i++) begin
      t[i] = CW'(baud_divisor(CLK_FREQ, baud_rate(3'(i))));
    end
    return t;
  endfunction

  localparam div_table_t DIV_TABLE = build_table();

  logic [CW-1:0] cnt;
  logic [CW-1:0] div_m1;
  logic [2:0]    sel_q;

  assign div_m1 = DIV_TABLE[baud_select] - CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      sel_q       <= '0;
      sample_tick <= 1'b0;
    end else begin
      sel_q       <= baud_select;
      sample_tick <= 1'b0;
      if (baud_select != sel_q) begin
        cnt <= '0;
      end else if (cnt == div_m1) begin
        cnt         <= '0;
        sample_tick <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_receiver_param.sv
// rtl/uart_receiver_param.sv - parametrised UART receiver; RX_MAJORITY_VOTE_EN selects 3-sample voting
module uart_receiver_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_EN,
  input  logic [2:0]           baud_select,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR,
  output logic                 Rx_BREAK
);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_width
    $error("uart_receiver_param: DATA_BITS must be 5..9");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_t            state, state_d;
  logic                 rx_meta, rx_sync, rx_prev;
  logic                 sample_tick;
  logic [2:0]           baud_q, cfg_baud;
  logic [1:0]           pmode_q;
  logic                 stop2_q;
  logic [3:0]           os_cnt, bit_cnt, hi_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q, parbit_q, perr_q, ferr_q;
  logic                 bit_val, mid_tick, parity_en, is_break;
  logic                 start_det, shift_en, par_sample, stop_sample, finish, brk_det;

  // Live baud code while idle so the tick phase tracks the host; frozen during a frame.
  assign cfg_baud = (state == S_IDLE) ? baud_select : baud_q;

  baud_controller #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .baud_select(cfg_baud),
    .sample_tick(sample_tick)
  );

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [3:0] DEC_CNT = 4'd8;
  logic s7_q, s8_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
    end else if (sample_tick) begin
      if (os_cnt == 4'd6) s7_q <= rx_sync;
      if (os_cnt == 4'd7) s8_q <= rx_sync;
    end
  end

  assign bit_val = (s7_q & s8_q) | (s7_q & rx_sync) | (s8_q & rx_sync);
`else
  localparam logic [3:0] DEC_CNT = 4'd7;
  assign bit_val = rx_sync;
`endif

  assign mid_tick  = sample_tick && (os_cnt == DEC_CNT);
  assign parity_en = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign is_break  = !bit_val && (shift_q == '0) && !(parity_en && parbit_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    start_det   = 1'b0;
    shift_en    = 1'b0;
    par_sample  = 1'b0;
    stop_sample = 1'b0;
    finish      = 1'b0;
    brk_det     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_sync) begin
          start_det = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (mid_tick) state_d = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_d = parity_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid_tick) begin
          par_sample = 1'b1;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (mid_tick) begin
          if (!stop_cnt && is_break) begin
            brk_det = 1'b1;
            finish  = 1'b1;
            state_d = S_BREAK_WAIT;
          end else if (stop2_q && !stop_cnt) begin
            stop_sample = 1'b1;
          end else begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK_WAIT: begin
        if (sample_tick && rx_sync && (hi_cnt == 4'd15)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Disable wins over everything, including a frame completing this cycle.
    if (!Rx_EN) begin
      state_d     = S_IDLE;
      start_det   = 1'b0;
      shift_en    = 1'b0;
      par_sample  = 1'b0;
      stop_sample = 1'b0;
      finish      = 1'b0;
      brk_det     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q   <= '0;
      pmode_q  <= PAR_NONE;
      stop2_q  <= 1'b0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      hi_cnt   <= '0;
      stop_cnt <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      parbit_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (start_det) begin
        baud_q   <= baud_select;
        pmode_q  <= parity_mode;
        stop2_q  <= stop_bits;
        os_cnt   <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        shift_q  <= '0;
        par_q    <= 1'b0;
        parbit_q <= 1'b0;
        perr_q   <= 1'b0;
        ferr_q   <= 1'b0;
      end else if (sample_tick && (state != S_IDLE) && (state != S_BREAK_WAIT)) begin
        os_cnt <= os_cnt + 4'd1;
      end
      if (shift_en) begin
        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
        par_q   <= par_q ^ bit_val;
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (par_sample) begin
        parbit_q <= bit_val;
        perr_q   <= par_q ^ bit_val ^ (pmode_q == PAR_ODD);
      end
      if (stop_sample) begin
        stop_cnt <= 1'b1;
        ferr_q   <= ferr_q | !bit_val;
      end
      if (brk_det) begin
        hi_cnt <= '0;
      end else if ((state == S_BREAK_WAIT) && sample_tick) begin
        hi_cnt <= rx_sync ? hi_cnt + 4'd1 : 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_BREAK  <= 1'b0;
    end else begin
      Rx_VALID <= finish;
      if (finish) begin
        Rx_DATA   <= brk_det ? '0 : shift_q;
        Rx_PERROR <= perr_q;
        Rx_FERROR <= brk_det | ferr_q | !bit_val;
      end
      if (brk_det)        Rx_BREAK <= 1'b1;
      else if (start_det) Rx_BREAK <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver_param.sv
// tb/tb_uart_receiver_param.sv - directed table-driven bench for uart_receiver_param
module tb_uart_receiver_param;
  import uart_pkg::*;

  localparam int TB_CLK = 1_843_200;
  localparam int BIT8   = 16 * 12;  // 9600 baud at TB_CLK: divisor 12
  localparam int BIT9   = 16 * 1;   // 115200 baud at TB_CLK: divisor 1

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_en;
  logic [2:0] baud_sel;
  logic [1:0] pmode;
  logic       stop2;
  logic       rxd8, rxd9;

  logic [7:0] data8;
  logic       valid8, perr8, ferr8, brk8;
  logic [8:0] data9;
  logic       valid9, perr9, ferr9, brk9;

  int tests = 0;
  int fails = 0;
  int v8_cnt = 0, v9_cnt = 0, wide8 = 0, wide9 = 0;
  logic prev8 = 1'b0, prev9 = 1'b0;

  always #5 clk = ~clk;

  uart_receiver_param #(.CLK_FREQ(TB_CLK), .DATA_BITS(8)) u_dut8 (
    .clk(clk), .reset(rst_n), .Rx_EN(rx_en), .baud_select(baud_sel),
    .parity_mode(pmode), .stop_bits(stop2), .RxD(rxd8),
    .Rx_DATA(data8), .Rx_VALID(valid8), .Rx_PERROR(perr8),
    .Rx_FERROR(ferr8), .Rx_BREAK(brk8)
  );

  uart_receiver_param #(.CLK_FREQ(TB_CLK), .DATA_BITS(9)) u_dut9 (
    .clk(clk), .reset(rst_n), .Rx_EN(rx_en), .baud_select(baud_sel),
    .parity_mode(pmode), .stop_bits(stop2), .RxD(rxd9),
    .Rx_DATA(data9), .Rx_VALID(valid9), .Rx_PERROR(perr9),
    .Rx_FERROR(ferr9), .Rx_BREAK(brk9)
  );

  always @(negedge clk) begin
    if (valid8) v8_cnt++;
    if (valid8 && prev8) wide8++;
    prev8 = valid8;
    if (valid9) v9_cnt++;
    if (valid9 && prev9) wide9++;
    prev9 = valid9;
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       two_stop;
    logic       par_bit;
    logic       stop1;
    logic       stop2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [8:0] d, input int nd, input logic [1:0] pm,
                       input logic pb, input logic two, input logic s1, input logic s2,
                       output logic [15:0] fb, output int nb);
    fb = '1;
    fb[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < nd; i++) begin
      fb[nb] = d[i];
      nb = nb + 1;
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      fb[nb] = pb;
      nb = nb + 1;
    end
    fb[nb] = s1;
    nb = nb + 1;
    if (two) begin
      fb[nb] = s2;
      nb = nb + 1;
    end
  endtask

  task automatic send(input logic [15:0] fb, input int nb, input int bclk,
                      input bit to9, input int abort_at);
    for (int i = 0; i < nb; i++) begin
      if (to9) rxd9 = fb[i];
      else     rxd8 = fb[i];
      if (i == abort_at) begin
        wait_clks(bclk / 2);
        rx_en = 1'b0;
        wait_clks(bclk - bclk / 2);
      end else begin
        wait_clks(bclk);
      end
    end
    if (to9) rxd9 = 1'b1;
    else     rxd8 = 1'b1;
  endtask

  task automatic frame8(input string name, input logic [7:0] d, input logic [1:0] pm,
                        input logic pb, input logic two, input logic s1, input logic s2,
                        input logic [7:0] ed, input logic ep, input logic ef);
    logic [15:0] fb;
    int nb, v0;
    pmode = pm;
    stop2 = two;
    build({1'b0, d}, 8, pm, pb, two, s1, s2, fb, nb);
    v0 = v8_cnt;
    send(fb, nb, BIT8, 1'b0, -1);
    wait_clks(2 * BIT8);
    check({name, " valid_count"}, v8_cnt, v0 + 1);
    check({name, " data"}, data8, ed);
    check({name, " perror"}, perr8, ep);
    check({name, " ferror"}, ferr8, ef);
    check({name, " break"}, brk8, 1'b0);
  endtask

  initial begin
    logic [15:0] fb;
    int nb, v0;

    vecs[0] = '{8'h55, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hA3, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};
    vecs[6] = '{8'hC6, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC6, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};

    rst_n = 1'b0;
    rx_en = 1'b1;
    baud_sel = 3'd3;
    pmode = 2'b00;
    stop2 = 1'b0;
    rxd8 = 1'b1;
    rxd9 = 1'b1;
    wait_clks(5);
    check("reset data", data8, 8'h00);
    check("reset valid", valid8, 1'b0);
    check("reset perror", perr8, 1'b0);
    check("reset ferror", ferr8, 1'b0);
    check("reset break", brk8, 1'b0);
    rst_n = 1'b1;

    check("divisor 50M/9600", baud_divisor(50_000_000, 9600), 326);
    check("divisor 50M/300", baud_divisor(50_000_000, 300), 10417);
    check("divisor 50M/115200", baud_divisor(50_000_000, 115200), 27);

    wait_clks(400);

    for (int i = 0; i < 8; i++) begin
      frame8($sformatf("vec%0d", i), vecs[i].data, vecs[i].pmode, vecs[i].par_bit,
             vecs[i].two_stop, vecs[i].stop1, vecs[i].stop2,
             vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
    end

    // Short low glitch must be rejected as a false start.
    v0 = v8_cnt;
    rxd8 = 1'b0;
    wait_clks(4);
    rxd8 = 1'b1;
    wait_clks(2 * BIT8);
    check("glitch valid_count", v8_cnt, v0);
    frame8("after_glitch", 8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);

    // Disable during data bit 4 (frame index 5): nothing produced, outputs held.
    pmode = 2'b00;
    stop2 = 1'b0;
    build(9'h05A, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, fb, nb);
    v0 = v8_cnt;
    send(fb, nb, BIT8, 1'b0, 5);
    wait_clks(2 * BIT8);
    check("abort valid_count", v8_cnt, v0);
    check("abort held data", data8, 8'h3C);
    check("abort held perror", perr8, 1'b0);
    check("abort held ferror", ferr8, 1'b0);
    rx_en = 1'b1;
    wait_clks(BIT8);
    frame8("after_abort", 8'h96, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0);

    // Enabling while the line is already low must not start a frame.
    v0 = v8_cnt;
    rx_en = 1'b0;
    rxd8 = 1'b0;
    wait_clks(20);
    rx_en = 1'b1;
    wait_clks(2 * BIT8);
    rxd8 = 1'b1;
    wait_clks(2 * BIT8);
    check("enable_low_line valid_count", v8_cnt, v0);
    check("enable_low_line data", data8, 8'h96);

    // Break on the 9-bit channel at 115200, even parity, one stop bit.
    baud_sel = 3'd7;
    pmode = 2'b01;
    stop2 = 1'b0;
    wait_clks(50);
    v0 = v9_cnt;
    rxd9 = 1'b0;
    wait_clks(12 * BIT9);
    rxd9 = 1'b1;
    wait_clks(4);
    check("break valid_count", v9_cnt, v0 + 1);
    check("break data", data9, 9'h000);
    check("break flag", brk9, 1'b1);
    check("break ferror", ferr9, 1'b1);

    // A low pulse before 16 high ticks is ignored while waiting out the break.
    wait_clks(2);
    rxd9 = 1'b0;
    wait_clks(12);
    rxd9 = 1'b1;
    wait_clks(40);
    check("break_wait valid_count", v9_cnt, v0 + 1);
    check("break_wait flag held", brk9, 1'b1);

    build(9'h1A5, 9, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, fb, nb);
    send(fb, nb, BIT9, 1'b1, -1);
    wait_clks(3 * BIT9);
    check("post_break valid_count", v9_cnt, v0 + 2);
    check("post_break data", data9, 9'h1A5);
    check("post_break perror", perr9, 1'b0);
    check("post_break ferror", ferr9, 1'b0);
    check("post_break flag cleared", brk9, 1'b0);

    check("valid8 single cycle", wide8, 0);
    check("valid9 single cycle", wide9, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
